// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one radix-8 Booth multiplier among NUM_REQ requesters.
// Each op goes IDLE (grant + operand capture) -> CALC (multiply, register) -> RESP (hold until taken).

module radix8_booth_multiplier (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);
  logic signed [18:0] m1, m2, m3, m4;
  logic        [18:0] bx;
  logic        [3:0]  grp;
  logic signed [18:0] sel;
  logic signed [18:0] pp;
  logic signed [35:0] acc;

  assign m1 = 19'(a_i);
  assign m2 = m1 <<< 1;
  assign m3 = m1 + m2;
  assign m4 = m1 <<< 2;
  // Multiplier with an implicit 0 below bit 0 and two sign bits on top: six overlapping 4-bit groups
  assign bx = {b_i[15], b_i[15], b_i, 1'b0};

  always_comb begin
    acc = '0;
    grp = '0;
    sel = '0;
    pp  = '0;
    for (int j = 0; j < 6; j++) begin
      grp = bx[3*j +: 4];
      unique case (grp)
        4'b0001, 4'b0010, 4'b1101, 4'b1110: sel = m1;
        4'b0011, 4'b0100, 4'b1011, 4'b1100: sel = m2;
        4'b0101, 4'b0110, 4'b1001, 4'b1010: sel = m3;
        4'b0111, 4'b1000:                   sel = m4;
        default:                            sel = '0;
      endcase
      pp  = grp[3] ? -sel : sel;
      acc = acc + (36'(pp) <<< (3*j));
    end
  end

  assign p_o = acc[31:0];
endmodule

module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][15:0]      req_a_i,
  input  logic [NUM_REQ-1:0][15:0]      req_b_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [31:0]                   rsp_product_o,
  output logic                          busy_o,
  output logic [15:0]                   ops_done_o
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [15:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_product_q, rsp_product_d;
  logic [15:0]        ops_done_q, ops_done_d;

  logic               found;
  logic [ID_W-1:0]    gnt_idx, scan_idx;
  logic signed [31:0] mul_p;

  radix8_booth_multiplier u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  // Scan starts just past the last winner, so the last winner has the lowest priority
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid_i[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && found && !rst_i) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    ops_done_d    = ops_done_q;
    unique case (state_q)
      IDLE: if (found) begin
        op_a_d  = req_a_i[gnt_idx];
        op_b_d  = req_b_i[gnt_idx];
        id_d    = gnt_idx;
        ptr_d   = gnt_idx;
        state_d = CALC;
      end
      CALC: begin
        rsp_product_d = mul_p;
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        ops_done_d  = ops_done_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      ops_done_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      ops_done_q    <= ops_done_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_product_o = rsp_product_q;
  assign busy_o        = (state_q != IDLE);
  assign ops_done_o    = ops_done_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the scheduler.

module tb_booth_mul_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][15:0] req_a = '0, req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_product;
  logic              busy;
  logic [15:0]       ops_done;

  int checks = 0;
  int errors = 0;

  booth_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_product_o(rsp_product), .busy_o(busy), .ops_done_o(ops_done)
  );

  always #5 clk = ~clk;

  // Drive at the falling edge, sample 1ns later: far from the rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops got %0d exp 0", ops_done); end
    checks++; if (rsp_id !== 2'd0 || rsp_product !== 32'd0)
      begin errors++; $display("FAIL reset_rsp got id %0d prod %0h exp 0 0", rsp_id, rsp_product); end
    cyc();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    cyc();
    req_valid = 4'b0001; req_a[0] = 16'd3; req_b[0] = 16'd2;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t1_grant got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL t1_calc got valid %b busy %b exp 0 1", rsp_valid, busy); end
    cyc();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 32'd6)
      begin errors++; $display("FAIL t1_rsp got v%b id%0d p%0d exp v1 id0 p6", rsp_valid, rsp_id, rsp_product); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++; if (ops_done !== 16'd1 || rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL t1_done got ops %0d v%b busy %b exp 1 0 0", ops_done, rsp_valid, busy); end
  endtask

  task automatic test_arith();
    logic signed [15:0] av [4];
    logic signed [15:0] bv [4];
    logic signed [31:0] ex [4];
    av = '{16'sd4660, -16'sd1, -16'sd32768, 16'sd32767};
    bv = '{16'sd0, 16'sd32767, -16'sd32768, -16'sd32768};
    ex = '{32'sd0, -32'sd32767, 32'sd1073741824, -32'sd1073709056};
    do_reset();
    for (int t = 0; t < 4; t++) begin
      cyc();
      req_valid = 4'b0100; req_a[2] = av[t]; req_b[2] = bv[t]; rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL t2_grant%0d got %b exp 0100", t, req_ready); end
      cyc();
      req_valid = '0;
      cyc();
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== ex[t])
        begin errors++; $display("FAIL t2_prod%0d got v%b id%0d p%0d exp v1 id2 p%0d", t, rsp_valid, rsp_id, $signed(rsp_product), ex[t]); end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int gnt[$];
    int gcyc[$];
    do_reset();
    cyc();
    for (int i = 0; i < N; i++) begin req_a[i] = 16'(i + 1); req_b[i] = 16'd10; end
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (rsp_valid) begin
        checks++; if (gnt.size() == 0 || rsp_id !== 2'(gnt[$]) || rsp_product !== 32'((int'(rsp_id) + 1) * 10))
          begin errors++; $display("FAIL t3_rsp got id%0d p%0d", rsp_id, rsp_product); end
      end
      for (int i = 0; i < N; i++) if (req_ready[i]) begin gnt.push_back(i); gcyc.push_back(c); end
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b0;
    checks++;
    if (gnt.size() < 5) begin errors++; $display("FAIL t3_count got %0d exp >=5", gnt.size()); end
    else begin
      if (gnt[0] != 0 || gnt[1] != 1 || gnt[2] != 2 || gnt[3] != 3 || gnt[4] != 0)
        begin errors++; $display("FAIL t3_order got %0d%0d%0d%0d%0d exp 01230", gnt[0], gnt[1], gnt[2], gnt[3], gnt[4]); end
      checks++;
      if (gcyc[1] - gcyc[0] != 3 || gcyc[4] - gcyc[3] != 3)
        begin errors++; $display("FAIL t3_spacing got %0d %0d exp 3 3", gcyc[1] - gcyc[0], gcyc[4] - gcyc[3]); end
    end
    cyc();
    rsp_ready = 1'b1; cyc(); cyc(); cyc(); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc();
    req_valid = 4'b0001; req_a[0] = -16'sd7; req_b[0] = 16'sd9;
    cyc();
    req_valid = '1;
    cyc();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_product !== -32'sd63 || rsp_id !== 2'd0 || req_ready !== 4'b0 || ops_done !== 16'd0)
        begin errors++; $display("FAIL t4_hold%0d got v%b p%0d id%0d rdy%b ops%0d", c, rsp_valid, $signed(rsp_product), rsp_id, req_ready, ops_done); end
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++; if (ops_done !== 16'd1 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL t4_release got ops%0d v%b exp 1 0", ops_done, rsp_valid); end
  endtask

  task automatic test_operand_hold();
    do_reset();
    cyc();
    req_valid = 4'b0001; req_a[0] = 16'sd100; req_b[0] = -16'sd3;
    cyc();
    req_a[0] = 16'sd5; req_b[0] = 16'sd5;
    cyc();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_product !== -32'sd300)
      begin errors++; $display("FAIL t5_sample got v%b p%0d exp v1 p-300", rsp_valid, $signed(rsp_product)); end
    req_valid = '0; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc();
    req_valid = 4'b0010; req_a[1] = 16'd7; req_b[1] = 16'd7;
    cyc();
    req_valid = '0; rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL t6_abort got v%b busy%b exp 0 0", rsp_valid, busy); end
    cyc();
    rst = 1'b0;
    cyc();
    req_valid = 4'b1001; req_a[0] = 16'd11; req_b[0] = 16'd3; req_a[3] = 16'd2; req_b[3] = 16'd2;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t6_grant got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 32'd33 || ops_done !== 16'd0)
      begin errors++; $display("FAIL t6_rsp got v%b id%0d p%0d ops%0d exp 1 0 33 0", rsp_valid, rsp_id, rsp_product, ops_done); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  // Transaction-level model: one op in flight, response due 2 cycles after the accept,
  // winner is the first valid requester after the previous winner.
  task automatic test_random();
    int  cnum = 0, acc_cyc = 0, last = N - 1, w, ops = 0;
    bit  pending = 0, exp_v;
    logic [N-1:0] exp_rdy;
    logic [1:0]   exp_id = '0;
    logic signed [31:0] exp_prod = '0;
    logic signed [15:0] corner [4];
    corner = '{-16'sd32768, 16'sd32767, -16'sd1, 16'sd0};
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      req_valid = 4'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        req_a[i] = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
        req_b[i] = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      end
      #1;
      cnum++;
      exp_rdy = '0; w = -1;
      if (!pending)
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_v = pending && (cnum >= acc_cyc + 2);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_rdy); end
      checks++; if (busy !== pending) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, pending); end
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, rsp_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rsp_id !== exp_id || rsp_product !== exp_prod)
          begin errors++; $display("FAIL rnd_rsp c%0d got id%0d p%0d exp id%0d p%0d", c, rsp_id, $signed(rsp_product), exp_id, exp_prod); end
      end
      checks++; if (ops_done !== 16'(ops)) begin errors++; $display("FAIL rnd_ops c%0d got %0d exp %0d", c, ops_done, ops); end
      if (exp_v && rsp_ready) begin pending = 0; ops++; end
      if (w >= 0) begin
        pending = 1; acc_cyc = cnum; exp_id = 2'(w); last = w;
        exp_prod = $signed(req_a[w]) * $signed(req_b[w]);
      end
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_operand_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
